// File: rtl/quad_encoder_gen_if.sv
// Bus bundle for quad_encoder_gen: write strobes and data, the stop request,
// the encoder pins and the move status outputs.
interface quad_encoder_gen_if;
    logic        writeSteps;
    logic [31:0] stepsData;
    logic        writePeriod;
    logic [15:0] periodData;
    logic        stop;
    logic        pinEncoderF;
    logic        pinEncoderB;
    logic        pinEncoderZ;
    logic        busy;
    logic        done;
    logic [31:0] position;
    logic [31:0] remaining;

    // Host side: issues commands and observes pins and status.
    modport master (
        output writeSteps, stepsData, writePeriod, periodData, stop,
        input  pinEncoderF, pinEncoderB, pinEncoderZ, busy, done, position, remaining
    );

    // Generator side.
    modport slave (
        input  writeSteps, stepsData, writePeriod, periodData, stop,
        output pinEncoderF, pinEncoderB, pinEncoderZ, busy, done, position, remaining
    );
endinterface

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder signal generator. Emits a commanded signed number of
// full quadrature cycles on A/B at a programmable phase period.
// Optional index output enabled by defining QENC_INDEX_EN.
module quad_encoder_gen #(
    parameter int unsigned DEFAULT_PERIOD = 100,
    parameter int unsigned MIN_PERIOD     = 2,
    parameter int unsigned PPR            = 1024
) (
    input logic               clk,
    input logic               resetn,
    quad_encoder_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t      state_reg, state_next;
    logic [15:0] period_reg, period_next;
    logic [15:0] divider_reg, divider_next;
    logic [1:0]  phase_reg, phase_next;
    logic        dir_reg, dir_next;            // 1 = reverse
    logic        pin_a_reg, pin_a_next;
    logic        pin_b_reg, pin_b_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        stop_pending_reg, stop_pending_next;
    logic [31:0] position_reg, position_next;
    logic [31:0] remaining_reg, remaining_next;

    logic [31:0] steps_mag;
    logic [15:0] period_wr;
    logic        tick;

    // |stepsData|; the most negative value maps to 2^31, which still fits.
    assign steps_mag = bus.stepsData[31] ? (~bus.stepsData + 32'd1) : bus.stepsData;
    assign period_wr = (bus.periodData < 16'(MIN_PERIOD)) ? 16'(MIN_PERIOD) : bus.periodData;
    // >= rather than == so a period shrunk below the running divider still fires.
    assign tick      = (state_reg == RUN) && (divider_reg >= period_reg - 16'd1);

    // Next-state and datapath: command load, phase advance, step bookkeeping.
    always_comb begin
        state_next        = state_reg;
        period_next       = period_reg;
        divider_next      = divider_reg;
        phase_next        = phase_reg;
        dir_next          = dir_reg;
        pin_a_next        = pin_a_reg;
        pin_b_next        = pin_b_reg;
        busy_next         = busy_reg;
        done_next         = 1'b0;
        stop_pending_next = stop_pending_reg;
        position_next     = position_reg;
        remaining_next    = remaining_reg;

        if (bus.writePeriod) begin
            period_next = period_wr;
        end

        case (state_reg)
            IDLE: begin
                if (bus.writeSteps) begin
                    if (steps_mag == 32'd0) begin
                        done_next = 1'b1;
                    end else begin
                        remaining_next    = steps_mag;
                        dir_next          = bus.stepsData[31];
                        divider_next      = 16'd0;
                        busy_next         = 1'b1;
                        stop_pending_next = 1'b0;
                        state_next        = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.stop) begin
                    stop_pending_next = 1'b1;
                end
                if (tick) begin
                    divider_next = 16'd0;
                    phase_next   = dir_reg ? (phase_reg - 2'd1) : (phase_reg + 2'd1);
                    // Gray-coded phase: A = p1^p0, B = p1 -> 00,10,11,01.
                    pin_a_next   = phase_next[1] ^ phase_next[0];
                    pin_b_next   = phase_next[1];
                    if (phase_next == 2'd0) begin
                        remaining_next = remaining_reg - 32'd1;
                        position_next  = dir_reg ? (position_reg - 32'd1) : (position_reg + 32'd1);
                        if (remaining_reg == 32'd1 || stop_pending_reg || bus.stop) begin
                            state_next = FINISH;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                        end
                    end
                end else begin
                    divider_next = divider_reg + 16'd1;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg        <= IDLE;
            period_reg       <= 16'(DEFAULT_PERIOD);
            divider_reg      <= 16'd0;
            phase_reg        <= 2'd0;
            dir_reg          <= 1'b0;
            pin_a_reg        <= 1'b0;
            pin_b_reg        <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            stop_pending_reg <= 1'b0;
            position_reg     <= 32'd0;
            remaining_reg    <= 32'd0;
        end else begin
            state_reg        <= state_next;
            period_reg       <= period_next;
            divider_reg      <= divider_next;
            phase_reg        <= phase_next;
            dir_reg          <= dir_next;
            pin_a_reg        <= pin_a_next;
            pin_b_reg        <= pin_b_next;
            busy_reg         <= busy_next;
            done_reg         <= done_next;
            stop_pending_reg <= stop_pending_next;
            position_reg     <= position_next;
            remaining_reg    <= remaining_next;
        end
    end

    assign bus.pinEncoderF = pin_a_reg;
    assign bus.pinEncoderB = pin_b_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.position    = position_reg;
    assign bus.remaining   = remaining_reg;

`ifdef QENC_INDEX_EN
    localparam int CW = (PPR > 1) ? $clog2(PPR) : 1;

    logic [CW-1:0] index_cnt_reg, index_cnt_next;
    logic [15:0]   z_cnt_reg, z_cnt_next;
    logic          z_reg, z_next;
    logic          step_fire;

    assign step_fire = tick && (phase_next == 2'd0);

    // Index: step counter modulo PPR; Z spans the phase-0 interval after wrap to 0.
    always_comb begin
        index_cnt_next = index_cnt_reg;
        z_cnt_next     = z_cnt_reg;
        z_next         = z_reg;
        if (z_reg) begin
            if (tick || z_cnt_reg >= period_reg - 16'd1) begin
                z_next     = 1'b0;
                z_cnt_next = 16'd0;
            end else begin
                z_cnt_next = z_cnt_reg + 16'd1;
            end
        end
        if (step_fire) begin
            if (dir_reg) begin
                index_cnt_next = (index_cnt_reg == '0) ? CW'(PPR - 1) : (index_cnt_reg - 1'b1);
            end else begin
                index_cnt_next = (index_cnt_reg == CW'(PPR - 1)) ? '0 : (index_cnt_reg + 1'b1);
            end
            if (index_cnt_next == '0) begin
                z_next     = 1'b1;
                z_cnt_next = 16'd0;
            end
        end
    end

    // Index registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            index_cnt_reg <= '0;
            z_cnt_reg     <= 16'd0;
            z_reg         <= 1'b0;
        end else begin
            index_cnt_reg <= index_cnt_next;
            z_cnt_reg     <= z_cnt_next;
            z_reg         <= z_next;
        end
    end

    assign bus.pinEncoderZ = z_reg;
`else
    assign bus.pinEncoderZ = 1'b0;
`endif
endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed testbench for quad_encoder_gen.
module tb_quad_encoder_gen;
    logic clk;
    logic resetn;
    quad_encoder_gen_if bus();

    quad_encoder_gen #(
        .DEFAULT_PERIOD(100),
        .MIN_PERIOD    (2),
        .PPR           (4)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [1:0] fwd_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] rev_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    // Capture results of one observed move.
    int         ntr, done_cnt, done_at, loop_cnt, z_high, nz;
    logic       busy_at_done;
    int         tr_time [64];
    logic [1:0] tr_val  [64];
    int         z_rise  [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn          = 1'b0;
        bus.writeSteps  = 1'b0;
        bus.stepsData   = 32'd0;
        bus.writePeriod = 1'b0;
        bus.periodData  = 16'd0;
        bus.stop        = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic write_period(input logic [15:0] p);
        bus.writePeriod = 1'b1;
        bus.periodData  = p;
        step();
        bus.writePeriod = 1'b0;
    endtask

    // Pulses writeSteps; returns one cycle after the strobe edge.
    task automatic write_steps(input logic [31:0] s);
        bus.writeSteps = 1'b1;
        bus.stepsData  = s;
        step();
        bus.writeSteps = 1'b0;
    endtask

    // Records pin transitions (cycle index relative to the busy-rise edge),
    // done pulses, Z activity and a loopback A-rise count. Optionally raises
    // stop once stop_at transitions have been seen.
    task automatic capture(input int max_cycles, input int stop_at);
        logic [1:0] prev, cur;
        logic       prev_z;
        bit         fin;
        ntr = 0; done_cnt = 0; done_at = -1; loop_cnt = 0; z_high = 0; nz = 0;
        busy_at_done = 1'bx; fin = 0;
        for (int i = 0; i < 64; i++) begin tr_time[i] = -1; tr_val[i] = 2'bxx; end
        for (int i = 0; i < 8; i++) z_rise[i] = -1;
        prev   = {bus.pinEncoderF, bus.pinEncoderB};
        prev_z = bus.pinEncoderZ;
        for (int k = 1; k <= max_cycles && !fin; k++) begin
            step();
            cur = {bus.pinEncoderF, bus.pinEncoderB};
            if (cur != prev) begin
                if (ntr < 64) begin tr_time[ntr] = k; tr_val[ntr] = cur; end
                ntr++;
                if (!prev[1] && cur[1]) loop_cnt += cur[0] ? -1 : 1;
                prev = cur;
            end
            if (bus.pinEncoderZ) begin
                z_high++;
                if (!prev_z && nz < 8) begin z_rise[nz] = k; nz++; end
            end
            prev_z = bus.pinEncoderZ;
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) begin done_at = k; busy_at_done = bus.busy; end
            end
            if (stop_at > 0 && ntr == stop_at) bus.stop = 1'b1;
            if (done_at > 0 && k >= done_at + 3) fin = 1;
        end
        bus.stop = 1'b0;
        $display("move: transitions=%0d done_at=%0d position=%0d remaining=%0d",
                 ntr, done_at, $signed(bus.position), bus.remaining);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if ({bus.pinEncoderF, bus.pinEncoderB, bus.pinEncoderZ} !== 3'b000) begin n_fail++; $display("FAIL reset_pins: got %b expected 000", {bus.pinEncoderF, bus.pinEncoderB, bus.pinEncoderZ}); end
        n_cmp++; if ({bus.busy, bus.done} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done: got %b expected 00", {bus.busy, bus.done}); end
        n_cmp++; if (bus.position !== 32'd0) begin n_fail++; $display("FAIL reset_position: got %h expected 0", bus.position); end
        n_cmp++; if (bus.remaining !== 32'd0) begin n_fail++; $display("FAIL reset_remaining: got %h expected 0", bus.remaining); end
    endtask

    task automatic test_forward();
        do_reset();
        write_period(16'd4);
        write_steps(32'd3);
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL fwd_busy_rise: got %b expected 1", bus.busy); end
        n_cmp++; if (bus.remaining !== 32'd3) begin n_fail++; $display("FAIL fwd_remaining_load: got %0d expected 3", bus.remaining); end
        capture(100, 0);
        n_cmp++; if (ntr !== 12) begin n_fail++; $display("FAIL fwd_transitions: got %0d expected 12", ntr); end
        for (int i = 0; i < 12; i++) begin
            n_cmp++; if (tr_time[i] !== 4 * (i + 1)) begin n_fail++; $display("FAIL fwd_edge_time[%0d]: got %0d expected %0d", i, tr_time[i], 4 * (i + 1)); end
            n_cmp++; if (tr_val[i] !== fwd_seq[(i + 1) % 4]) begin n_fail++; $display("FAIL fwd_edge_value[%0d]: got %b expected %b", i, tr_val[i], fwd_seq[(i + 1) % 4]); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL fwd_done_count: got %0d expected 1", done_cnt); end
        n_cmp++; if (done_at !== 48) begin n_fail++; $display("FAIL fwd_done_time: got %0d expected 48", done_at); end
        n_cmp++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL fwd_busy_at_done: got %b expected 0", busy_at_done); end
        n_cmp++; if (bus.position !== 32'd3) begin n_fail++; $display("FAIL fwd_position: got %0d expected 3", bus.position); end
        n_cmp++; if (bus.remaining !== 32'd0) begin n_fail++; $display("FAIL fwd_remaining: got %0d expected 0", bus.remaining); end
        n_cmp++; if (loop_cnt !== 3) begin n_fail++; $display("FAIL fwd_loopback: got %0d expected 3", loop_cnt); end
`ifndef QENC_INDEX_EN
        n_cmp++; if (z_high !== 0) begin n_fail++; $display("FAIL fwd_z_idle: got %0d expected 0", z_high); end
`endif
    endtask

    task automatic test_reverse();
        do_reset();
        write_period(16'd2);
        write_steps(-32'sd2);
        capture(60, 0);
        n_cmp++; if (ntr !== 8) begin n_fail++; $display("FAIL rev_transitions: got %0d expected 8", ntr); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (tr_time[i] !== 2 * (i + 1)) begin n_fail++; $display("FAIL rev_edge_time[%0d]: got %0d expected %0d", i, tr_time[i], 2 * (i + 1)); end
            n_cmp++; if (tr_val[i] !== rev_seq[(i + 1) % 4]) begin n_fail++; $display("FAIL rev_edge_value[%0d]: got %b expected %b", i, tr_val[i], rev_seq[(i + 1) % 4]); end
        end
        n_cmp++; if (bus.position !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL rev_position: got %h expected fffffffe", bus.position); end
        n_cmp++; if (loop_cnt !== -2) begin n_fail++; $display("FAIL rev_loopback: got %0d expected -2", loop_cnt); end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rev_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_stop();
        do_reset();
        write_period(16'd2);
        write_steps(32'd10);
        capture(200, 10);
        n_cmp++; if (ntr !== 12) begin n_fail++; $display("FAIL stop_transitions: got %0d expected 12", ntr); end
        n_cmp++; if ({bus.pinEncoderF, bus.pinEncoderB} !== 2'b00) begin n_fail++; $display("FAIL stop_pins: got %b expected 00", {bus.pinEncoderF, bus.pinEncoderB}); end
        n_cmp++; if (bus.position !== 32'd3) begin n_fail++; $display("FAIL stop_position: got %0d expected 3", bus.position); end
        n_cmp++; if (bus.remaining !== 32'd7) begin n_fail++; $display("FAIL stop_remaining: got %0d expected 7", bus.remaining); end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL stop_done_count: got %0d expected 1", done_cnt); end
        n_cmp++; if (done_at !== 24) begin n_fail++; $display("FAIL stop_done_time: got %0d expected 24", done_at); end
    endtask

    task automatic test_clamp_and_zero();
        do_reset();
        write_period(16'd0);
        write_steps(32'd1);
        capture(40, 0);
        n_cmp++; if (ntr !== 4) begin n_fail++; $display("FAIL clamp_transitions: got %0d expected 4", ntr); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (tr_time[i] !== 2 * (i + 1)) begin n_fail++; $display("FAIL clamp_edge_time[%0d]: got %0d expected %0d", i, tr_time[i], 2 * (i + 1)); end
        end
        write_steps(32'd0);
        n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b expected 1", bus.done); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b expected 0", bus.busy); end
        step();
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL zero_done_width: got %b expected 0", bus.done); end
        step();
        step();
        n_cmp++; if ({bus.busy, bus.pinEncoderF, bus.pinEncoderB} !== 3'b000) begin n_fail++; $display("FAIL zero_no_motion: got %b expected 000", {bus.busy, bus.pinEncoderF, bus.pinEncoderB}); end
        n_cmp++; if (bus.position !== 32'd1) begin n_fail++; $display("FAIL zero_position: got %0d expected 1", bus.position); end
    endtask

    task automatic test_back_to_back();
        int  waited;
        do_reset();
        write_period(16'd2);
        write_steps(32'd5);
        step(); step(); step();
        write_steps(32'd100);
        n_cmp++; if (bus.remaining !== 32'd5) begin n_fail++; $display("FAIL ignore_remaining: got %0d expected 5", bus.remaining); end
        waited = 0;
        while (bus.done !== 1'b1 && waited < 200) begin step(); waited++; end
        n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL ignore_done_timeout: got %b expected 1", bus.done); end
        n_cmp++; if (bus.position !== 32'd5) begin n_fail++; $display("FAIL ignore_position: got %0d expected 5", bus.position); end
        $display("move: ignored write, position=%0d after %0d cycles", bus.position, waited);
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        write_period(16'd2);
        write_steps(32'd5);
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if ({bus.busy, bus.pinEncoderF, bus.pinEncoderB} !== 3'b111) begin n_fail++; $display("FAIL midreset_pre: got %b expected 111", {bus.busy, bus.pinEncoderF, bus.pinEncoderB}); end
        resetn = 1'b0;
        step();
        n_cmp++; if ({bus.pinEncoderF, bus.pinEncoderB, bus.pinEncoderZ, bus.busy, bus.done} !== 5'b0) begin n_fail++; $display("FAIL midreset_outputs: got %b expected 00000", {bus.pinEncoderF, bus.pinEncoderB, bus.pinEncoderZ, bus.busy, bus.done}); end
        n_cmp++; if (bus.remaining !== 32'd0) begin n_fail++; $display("FAIL midreset_remaining: got %0d expected 0", bus.remaining); end
        resetn = 1'b1;
        write_steps(32'd1);
        for (int i = 0; i < 99; i++) step();
        n_cmp++; if ({bus.pinEncoderF, bus.pinEncoderB} !== 2'b00) begin n_fail++; $display("FAIL default_period_early: got %b expected 00", {bus.pinEncoderF, bus.pinEncoderB}); end
        step();
        n_cmp++; if ({bus.pinEncoderF, bus.pinEncoderB} !== 2'b10) begin n_fail++; $display("FAIL default_period_edge: got %b expected 10", {bus.pinEncoderF, bus.pinEncoderB}); end
        do_reset();
    endtask

`ifdef QENC_INDEX_EN
    task automatic test_index();
        do_reset();
        write_period(16'd2);
        write_steps(32'd9);
        capture(120, 0);
        n_cmp++; if (nz !== 2) begin n_fail++; $display("FAIL index_pulses: got %0d expected 2", nz); end
        n_cmp++; if (z_rise[0] !== 32) begin n_fail++; $display("FAIL index_rise0: got %0d expected 32", z_rise[0]); end
        n_cmp++; if (z_rise[1] !== 64) begin n_fail++; $display("FAIL index_rise1: got %0d expected 64", z_rise[1]); end
        n_cmp++; if (z_high !== 4) begin n_fail++; $display("FAIL index_width: got %0d expected 4", z_high); end
        write_steps(-32'sd1);
        capture(40, 0);
        n_cmp++; if (bus.position !== 32'd8) begin n_fail++; $display("FAIL index_rev_position: got %0d expected 8", bus.position); end
        n_cmp++; if (nz !== 1 || z_rise[0] !== 8) begin n_fail++; $display("FAIL index_rev_pulse: got %0d at %0d expected 1 at 8", nz, z_rise[0]); end
        n_cmp++; if (z_high !== 2) begin n_fail++; $display("FAIL index_rev_width: got %0d expected 2", z_high); end
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_stop();
        test_clamp_and_zero();
        test_back_to_back();
        test_reset_mid_move();
`ifdef QENC_INDEX_EN
        test_index();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
